// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide units: FSM state
// encodings, Booth recoding operations and default operand width.
package mult_div_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'd0,
      BOOTH_ADD = 2'd1,
      BOOTH_SUB = 2'd2
   } booth_op_t;

   // Radix-2 Booth recoding of the pair {Q[0], Q_-1}.
   function automatic booth_op_t boothOp(input logic q0, input logic qm1);
      booth_op_t op;
      case ({q0, qm1})
         2'b01:   op = BOOTH_ADD;
         2'b10:   op = BOOTH_SUB;
         default: op = BOOTH_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mult_booth_if.sv
// StartMult/MultEnd handshake between the control unit and the Booth multiplier.
interface mult_booth_if
   import mult_div_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH);

   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             busy;
   logic             mult_end;

   modport master (
      output start, a_in, b_in,
      input  hi_out, lo_out, busy, mult_end
   );

   modport slave (
      input  start, a_in, b_in,
      output hi_out, lo_out, busy, mult_end
   );

endinterface

// File: rtl/mult_booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into
// acc, then arithmetic right shift of {acc, Q, Q_-1}.
module mult_booth_step
   import mult_div_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH)
   (
   input  logic signed [WIDTH:0]   acc,
   input  logic        [WIDTH-1:0] q,
   input  logic                    qm1,
   input  logic signed [WIDTH:0]   m,
   output logic signed [WIDTH:0]   accOut,
   output logic        [WIDTH-1:0] qOut,
   output logic                    qm1Out
   );

   logic signed [WIDTH:0] sum;

   always_comb begin
      sum = acc;
      case (boothOp(q[0], qm1))
         BOOTH_ADD: sum = acc + m;
         BOOTH_SUB: sum = acc - m;
         default:   sum = acc;
      endcase
   end

   // acc is one bit wider than the operands, so its MSB is the true sign.
   assign accOut = {sum[WIDTH], sum[WIDTH:1]};
   assign qOut   = {sum[0], q[WIDTH-1:1]};
   assign qm1Out = q[0];

endmodule

// File: rtl/mult_booth.sv
// Multicycle signed WIDTHxWIDTH Booth multiplier: one Booth step per cycle,
// registered HI/LO product and a one-cycle MultEnd pulse.
module mult_booth
   import mult_div_pkg::*;
   #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
   )
   (
   input  logic         clock,
   input  logic         reset,
   mult_booth_if.slave  bus
   );

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t                  state, nextState;
   logic [CNT_W-1:0]        cnt;
   logic signed [WIDTH:0]   accReg, mReg, accNext;
   logic        [WIDTH-1:0] qReg, qNext;
   logic                    qm1Reg, qm1Next;
   logic                    loadOp, stepEn, lastStep;

   mult_booth_step #(.WIDTH(WIDTH)) uStep (
      .acc    (accReg),
      .q      (qReg),
      .qm1    (qm1Reg),
      .m      (mReg),
      .accOut (accNext),
      .qOut   (qNext),
      .qm1Out (qm1Next)
   );

   always_comb begin
      nextState    = state;
      loadOp       = 1'b0;
      stepEn       = 1'b0;
      lastStep     = 1'b0;
      bus.busy     = 1'b0;
      bus.mult_end = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               loadOp    = 1'b1;
               nextState = ST_RUN;
            end
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            stepEn   = 1'b1;
            if (cnt == LAST_CNT) begin
               lastStep  = 1'b1;
               nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.mult_end = 1'b1;
            nextState    = ST_IDLE;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         accReg     <= '0;
         qReg       <= '0;
         qm1Reg     <= 1'b0;
         mReg       <= '0;
         bus.hi_out <= '0;
         bus.lo_out <= '0;
      end else begin
         state <= nextState;
         if (loadOp) begin
            mReg   <= {bus.a_in[WIDTH-1], bus.a_in};
            qReg   <= bus.b_in;
            qm1Reg <= 1'b0;
            accReg <= '0;
            cnt    <= '0;
         end else if (stepEn) begin
            accReg <= accNext;
            qReg   <= qNext;
            qm1Reg <= qm1Next;
            cnt    <= cnt + CNT_W'(1);
            // Final step: the low WIDTH bits of acc and Q hold the exact product.
            if (lastStep) begin
               bus.hi_out <= accNext[WIDTH-1:0];
               bus.lo_out <= qNext;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed boundary/handshake scenarios plus
// randomized operands compared against a plain signed 64-bit product.
module tb_mult_booth;

   logic clock;
   logic reset;
   int   checkCnt = 0;
   int   passCnt  = 0;

   mult_booth_if #(.WIDTH(32)) mbIf ();

   mult_booth #(.WIDTH(32), .CNT_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (mbIf.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCnt++;
      if (obs === exp) passCnt++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
   endtask

   function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   function automatic logic [63:0] prod();
      return {mbIf.hi_out, mbIf.lo_out};
   endfunction

   // Single operation: start in cycle 0, busy 1..32, mult_end in 33, hold in 34.
   task automatic doOp(input logic [31:0] a, input logic [31:0] b, input string tag);
      int badCyc = 0;
      logic [63:0] exp;
      exp = refProduct(a, b);
      @(negedge clock);
      mbIf.start = 1'b1; mbIf.a_in = a; mbIf.b_in = b;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clock);
         if (c == 1) begin
            mbIf.start = 1'b0; mbIf.a_in = $urandom; mbIf.b_in = $urandom;
         end
         if (mbIf.busy !== 1'b1 || mbIf.mult_end !== 1'b0) badCyc++;
      end
      checkVal({tag, ":busyWindow"}, 64'(badCyc), 64'd0);
      @(negedge clock);
      checkVal({tag, ":multEnd33"}, 64'(mbIf.mult_end), 64'd1);
      checkVal({tag, ":busy33"}, 64'(mbIf.busy), 64'd0);
      checkVal({tag, ":product"}, prod(), exp);
      @(negedge clock);
      checkVal({tag, ":multEnd34"}, 64'(mbIf.mult_end), 64'd0);
      checkVal({tag, ":hold34"}, prod(), exp);
   endtask

   initial begin
      int ends, endCyc, bad;
      logic [63:0] endProd;
      reset = 1'b1;
      mbIf.start = 1'b0; mbIf.a_in = '0; mbIf.b_in = '0;
      repeat (3) @(negedge clock);
      checkVal("reset:product", prod(), 64'd0);
      checkVal("reset:busy", 64'(mbIf.busy), 64'd0);
      checkVal("reset:multEnd", 64'(mbIf.mult_end), 64'd0);
      reset = 1'b0;

      doOp(32'd3, 32'd5, "3x5");
      checkVal("3x5:lo", 64'(mbIf.lo_out), 64'h0000000F);
      doOp(32'hFFFFFFFF, 32'h00000001, "m1x1");
      doOp(32'hFFFFFFF9, 32'hFFFFFFFD, "m7xm3");
      checkVal("m7xm3:lo", 64'(mbIf.lo_out), 64'h00000015);
      doOp(32'h80000000, 32'h80000000, "minxmin");
      checkVal("minxmin:hi", 64'(mbIf.hi_out), 64'h40000000);
      doOp(32'h7FFFFFFF, 32'h7FFFFFFF, "maxxmax");
      doOp(32'h80000000, 32'h00000001, "minx1");
      for (int i = 0; i < 12; i++) doOp($urandom, $urandom, $sformatf("rand%0d", i));

      // start held high, operands changed mid-run
      ends = 0; endCyc = -1; endProd = '0;
      @(negedge clock);
      mbIf.start = 1'b1; mbIf.a_in = 32'd6; mbIf.b_in = 32'd7;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (c == 5) begin mbIf.a_in = 32'h100; mbIf.b_in = 32'h100; end
         if (mbIf.mult_end === 1'b1) begin
            ends++; endCyc = c; endProd = prod();
         end
         if (c == 33) mbIf.start = 1'b0;
      end
      checkVal("hold:ends", 64'(ends), 64'd1);
      checkVal("hold:endCycle", 64'(endCyc), 64'd33);
      checkVal("hold:product", endProd, 64'h2A);

      // reset in the middle of a 3x5 operation
      @(negedge clock);
      mbIf.start = 1'b1; mbIf.a_in = 32'd3; mbIf.b_in = 32'd5;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clock);
         if (c == 1) mbIf.start = 1'b0;
         if (c == 10) reset = 1'b1;
      end
      reset = 1'b0;
      checkVal("abort:product", prod(), 64'd0);
      checkVal("abort:busy", 64'(mbIf.busy), 64'd0);
      ends = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (mbIf.mult_end === 1'b1) ends++;
      end
      checkVal("abort:noEnd", 64'(ends), 64'd0);
      doOp(32'd2, 32'd2, "after2x2");

      // back-to-back: start in DONE ignored, accepted in the next IDLE cycle
      bad = 0; endCyc = -1; endProd = '0;
      @(negedge clock);
      mbIf.start = 1'b1; mbIf.a_in = 32'd2; mbIf.b_in = 32'd3;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clock);
         if (c == 1) mbIf.start = 1'b0;
         if (c == 33) begin
            checkVal("b2b:firstEnd", 64'(mbIf.mult_end), 64'd1);
            checkVal("b2b:firstProd", prod(), 64'd6);
            mbIf.start = 1'b1; mbIf.a_in = 32'd4; mbIf.b_in = 32'd5;
         end
         if (c == 35) mbIf.start = 1'b0;
         if (c >= 34 && c <= 66 && (prod() !== 64'd6 || mbIf.mult_end !== 1'b0)) bad++;
         if (c > 33 && mbIf.mult_end === 1'b1 && endCyc < 0) begin
            endCyc = c; endProd = prod();
         end
      end
      checkVal("b2b:holdWindow", 64'(bad), 64'd0);
      checkVal("b2b:secondCycle", 64'(endCyc), 64'd67);
      checkVal("b2b:secondProd", endProd, 64'h14);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
